distr_arith_unit: RTL and testbench



---
 rtl/fir_da_pkg.sv | 53 +++++
 rtl/distr_arith_unit_if.sv | 34 +++
 rtl/da_lut.sv | 28 ++
 rtl/distr_arith_unit.sv | 87 ++++++++
 tb/tb_distr_arith_unit.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/fir_da_pkg.sv
// rtl/fir_da_pkg.sv - shared widths, coefficient set and LUT helper for the DA FIR engine
//
// Purpose: single home for the FIR datapath widths, the 64-tap signed
// coefficient set and the function that folds a group of coefficients into
// one distributed-arithmetic LUT entry. Replacing COEFS retargets the filter
// with no RTL change elsewhere.
// Ports: none (package).
package fir_da_pkg;

  localparam int DATA_W         = 16;
  localparam int COEF_W         = 16;
  localparam int SUM_W          = 32;
  localparam int NUM_TAPS       = 64;
  localparam int TAPS_PER_GROUP = 8;
  localparam int NUM_GROUPS     = 8;

  // A LUT entry adds up to TAPS_PER_GROUP coefficients; the bit-slice partial
  // sum adds NUM_GROUPS LUT entries. Each stage grows by log2 of its fan-in.
  localparam int LUT_W  = COEF_W + $clog2(TAPS_PER_GROUP);
  localparam int PSUM_W = LUT_W + $clog2(NUM_GROUPS);
  localparam int CNT_W  = $clog2(DATA_W);

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [LUT_W-1:0]  lut_t;
  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  // Default coefficient set: h[k] = k + 1.
  localparam coef_t COEFS [NUM_TAPS] = '{
    16'sd1,  16'sd2,  16'sd3,  16'sd4,  16'sd5,  16'sd6,  16'sd7,  16'sd8,
    16'sd9,  16'sd10, 16'sd11, 16'sd12, 16'sd13, 16'sd14, 16'sd15, 16'sd16,
    16'sd17, 16'sd18, 16'sd19, 16'sd20, 16'sd21, 16'sd22, 16'sd23, 16'sd24,
    16'sd25, 16'sd26, 16'sd27, 16'sd28, 16'sd29, 16'sd30, 16'sd31, 16'sd32,
    16'sd33, 16'sd34, 16'sd35, 16'sd36, 16'sd37, 16'sd38, 16'sd39, 16'sd40,
    16'sd41, 16'sd42, 16'sd43, 16'sd44, 16'sd45, 16'sd46, 16'sd47, 16'sd48,
    16'sd49, 16'sd50, 16'sd51, 16'sd52, 16'sd53, 16'sd54, 16'sd55, 16'sd56,
    16'sd57, 16'sd58, 16'sd59, 16'sd60, 16'sd61, 16'sd62, 16'sd63, 16'sd64
  };

  // LUT entry for one group: sum of the coefficients whose tap bit is set.
  function automatic lut_t lut_entry(input int group,
                                     input logic [TAPS_PER_GROUP-1:0] addr);
    lut_t acc;
    acc = '0;
    for (int i = 0; i < TAPS_PER_GROUP; i++) begin
      if (addr[i]) begin
        acc = acc + lut_t'(COEFS[group * TAPS_PER_GROUP + i]);
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/distr_arith_unit_if.sv
// rtl/distr_arith_unit_if.sv - bit-slice input and result bus of the DA engine
//
// Purpose: bundles the eight per-group tap bit slices and the filter result.
// Signals:
//   x1_bit..x8_bit  8 each  current bit of taps 8(g-1)+i, bit i is tap 8(g-1)+i
//   sum             32      signed filter result, held between updates
//   valid           1       one-cycle pulse when sum updates
// Modports: master drives the bit slices (tap shift registers side),
//           slave is the DA engine.
interface distr_arith_unit_if;
  import fir_da_pkg::*;

  logic [TAPS_PER_GROUP-1:0] x1_bit;
  logic [TAPS_PER_GROUP-1:0] x2_bit;
  logic [TAPS_PER_GROUP-1:0] x3_bit;
  logic [TAPS_PER_GROUP-1:0] x4_bit;
  logic [TAPS_PER_GROUP-1:0] x5_bit;
  logic [TAPS_PER_GROUP-1:0] x6_bit;
  logic [TAPS_PER_GROUP-1:0] x7_bit;
  logic [TAPS_PER_GROUP-1:0] x8_bit;
  sum_t                      sum;
  logic                      valid;

  modport master (
    output x1_bit, x2_bit, x3_bit, x4_bit, x5_bit, x6_bit, x7_bit, x8_bit,
    input  sum, valid
  );

  modport slave (
    input  x1_bit, x2_bit, x3_bit, x4_bit, x5_bit, x6_bit, x7_bit, x8_bit,
    output sum, valid
  );

endinterface

// File: rtl/da_lut.sv
// rtl/da_lut.sv - constant 256-entry partial-sum ROM for one DA tap group
//
// Purpose: maps the current bit of the group's 8 taps to the sum of the
// coefficients of the taps whose bit is set. Contents are fixed at
// elaboration from COEFS; there is no runtime load.
// Ports:
//   addr_i  in   8      current bit of the group's taps, bit i is tap 8*GROUP+i
//   data_o  out  LUT_W  signed coefficient partial sum
module da_lut
  import fir_da_pkg::*;
#(
  parameter int GROUP = 0
) (
  input  logic [TAPS_PER_GROUP-1:0] addr_i,
  output lut_t                      data_o
);

  localparam int DEPTH = 2 ** TAPS_PER_GROUP;

  lut_t rom [DEPTH];

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    assign rom[a] = lut_entry(GROUP, TAPS_PER_GROUP'(a));
  end

  assign data_o = rom[addr_i];

endmodule

// File: rtl/distr_arith_unit.sv
// rtl/distr_arith_unit.sv - bit-serial distributed-arithmetic MAC for the 64-tap FIR
//
// Purpose: each cycle takes bit j of all 64 samples (LSB first), looks up the
// per-group coefficient partial sums, adds them and shift-accumulates the
// result; every 16 cycles it publishes the 32-bit filter output.
// Ports:
//   clk    in  1  single clock, rising edge
//   reset  in  1  synchronous, active-high
//   bus    slave modport of distr_arith_unit_if (x1_bit..x8_bit in, sum/valid out)
module distr_arith_unit
  import fir_da_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  distr_arith_unit_if.slave bus
);

  logic [TAPS_PER_GROUP-1:0] xg [NUM_GROUPS];
  lut_t                      lut_out [NUM_GROUPS];
  psum_t                     psum;

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  sum_t             acc_q, acc_d;
  sum_t             sum_q, sum_d;
  logic             valid_q, valid_d;
  sum_t             term;
  logic             last_bit;

  assign xg[0] = bus.x1_bit;
  assign xg[1] = bus.x2_bit;
  assign xg[2] = bus.x3_bit;
  assign xg[3] = bus.x4_bit;
  assign xg[4] = bus.x5_bit;
  assign xg[5] = bus.x6_bit;
  assign xg[6] = bus.x7_bit;
  assign xg[7] = bus.x8_bit;

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_lut
    da_lut #(.GROUP(g)) u_lut (
      .addr_i (xg[g]),
      .data_o (lut_out[g])
    );
  end

  // Adder tree across groups: signed partial sum for this bit slice.
  always_comb begin
    psum = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      psum = psum + psum_t'(lut_out[g]);
    end
  end

  // The accumulator is kept at SUM_W bits. Two's-complement add/sub/shift are
  // exact modulo 2^SUM_W, so this equals the exact result truncated to SUM_W.
  always_comb begin
    term      = sum_t'(psum) <<< bit_cnt_q;
    last_bit  = (bit_cnt_q == CNT_W'(DATA_W - 1));
    bit_cnt_d = bit_cnt_q + CNT_W'(1);
    acc_d     = acc_q + term;
    sum_d     = sum_q;
    valid_d   = 1'b0;
    if (last_bit) begin
      // Sample MSB carries weight -2^(DATA_W-1); fold it in and publish.
      sum_d   = acc_q - term;
      acc_d   = '0;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q <= '0;
      acc_q     <= '0;
      sum_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      acc_q     <= acc_d;
      sum_q     <= sum_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_distr_arith_unit.sv
// tb/tb_distr_arith_unit.sv - directed self-checking bench for distr_arith_unit
module tb_distr_arith_unit;

  logic clk;
  logic reset;
  int   checks;
  int   passed;

  logic [15:0] smp [64];
  logic [31:0] exp_held;

  distr_arith_unit_if bus_if ();

  distr_arith_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic clear_samples();
    for (int k = 0; k < 64; k++) smp[k] = 16'h0000;
  endtask

  task automatic drive_bits(input int j);
    logic [7:0] b [8];
    for (int g = 0; g < 8; g++)
      for (int i = 0; i < 8; i++)
        b[g][i] = smp[g * 8 + i][j];
    bus_if.x1_bit = b[0];
    bus_if.x2_bit = b[1];
    bus_if.x3_bit = b[2];
    bus_if.x4_bit = b[3];
    bus_if.x5_bit = b[4];
    bus_if.x6_bit = b[5];
    bus_if.x7_bit = b[6];
    bus_if.x8_bit = b[7];
  endtask

  task automatic drive_random();
    bus_if.x1_bit = 8'($urandom);
    bus_if.x2_bit = 8'($urandom);
    bus_if.x3_bit = 8'($urandom);
    bus_if.x4_bit = 8'($urandom);
    bus_if.x5_bit = 8'($urandom);
    bus_if.x6_bit = 8'($urandom);
    bus_if.x7_bit = 8'($urandom);
    bus_if.x8_bit = 8'($urandom);
  endtask

  // One full 16-cycle frame from smp; previous result must hold until the
  // last edge, where the new result appears with a valid pulse.
  task automatic run_frame(input string tag, input logic [31:0] exp_res);
    for (int j = 0; j < 16; j++) begin
      drive_bits(j);
      @(posedge clk);
      #1;
      if (j < 15) begin
        check({tag, "_valid_low"}, {31'd0, bus_if.valid}, 32'd0);
        check({tag, "_held"}, bus_if.sum, exp_held);
      end else begin
        check({tag, "_valid"}, {31'd0, bus_if.valid}, 32'd1);
        check({tag, "_sum"}, bus_if.sum, exp_res);
      end
    end
    exp_held = exp_res;
  endtask

  initial begin
    checks   = 0;
    passed   = 0;
    exp_held = 32'd0;
    reset    = 1'b1;
    clear_samples();
    drive_random();

    // Reset held three cycles with random inputs.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      drive_random();
    end
    check("reset_sum", bus_if.sum, 32'd0);
    check("reset_valid", {31'd0, bus_if.valid}, 32'd0);
    reset = 1'b0;

    // Impulse on tap 0.
    clear_samples();
    smp[0] = 16'h0001;
    run_frame("impulse", 32'h0000_0001);

    // All taps = 1: 1+2+...+64.
    for (int k = 0; k < 64; k++) smp[k] = 16'h0001;
    run_frame("all_ones", 32'h0000_0820);

    // Tap 63 = -1, h[63] = 64.
    clear_samples();
    smp[63] = 16'hFFFF;
    run_frame("negative", 32'hFFFF_FFC0);

    // Tap 5 max positive, tap 10 max negative.
    clear_samples();
    smp[5]  = 16'h7FFF;
    smp[10] = 16'h8000;
    run_frame("mixed", 32'hFFFD_7FFA);

    // Reset at j = 7 of an all-ones frame.
    for (int k = 0; k < 64; k++) smp[k] = 16'h0001;
    for (int j = 0; j < 7; j++) begin
      drive_bits(j);
      @(posedge clk);
      #1;
      check("midrst_held", bus_if.sum, exp_held);
    end
    drive_bits(7);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_sum", bus_if.sum, 32'd0);
    check("midrst_valid", {31'd0, bus_if.valid}, 32'd0);
    reset    = 1'b0;
    exp_held = 32'd0;

    // Back-to-back frames after reset.
    clear_samples();
    smp[0] = 16'h0001;
    run_frame("b2b_impulse", 32'h0000_0001);
    for (int k = 0; k < 64; k++) smp[k] = 16'h0001;
    run_frame("b2b_all_ones", 32'h0000_0820);
    clear_samples();
    run_frame("b2b_zero", 32'h0000_0000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
